fifo_var_read: RTL and testbench



---
 rtl/fifo_var_read.sv | 62 ++++++
 tb/tb_fifo_var_read.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/fifo_var_read.sv
// fifo_var_read: byte FIFO taking fixed 4-byte write beats and returning 1/2/4/8-byte reads.
module fifo_var_read #(
   parameter int FIFO_SIZE   = 256,
   parameter int WRITE_BYTES = 4,
   parameter int READ_MOST   = 8,
   localparam int AW = $clog2(FIFO_SIZE),
   localparam int CW = AW + 1
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   valid_in,
   input  logic [8*WRITE_BYTES-1:0] data_in,
   output logic                   ready_in,
   input  logic                   rd_req,
   input  logic [1:0]             size,
   output logic                   valid_out,
   output logic [8*READ_MOST-1:0] data_out,
   output logic [1:0]             size_out,
   output logic [CW-1:0]          count,
   output logic                   empty
);
   localparam logic [CW-1:0] LIM = CW'(FIFO_SIZE - WRITE_BYTES);
   logic [7:0] mem [0:FIFO_SIZE-1];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [3:0] n;
   logic wr_ok, rd_ok;
   logic [8*READ_MOST-1:0] rd_data;
   assign ready_in = count <= LIM;
   assign empty    = count == '0;
   assign n        = 4'd1 << size;
   assign wr_ok    = valid_in & ready_in;
   // occupancy is judged on registered count, so same-cycle writes are invisible to the read
   assign rd_ok    = rd_req & (count >= CW'(n));
   always_comb begin
      rd_data = '0;
      for (int k = 0; k < READ_MOST; k++)
         rd_data[8*k+:8] = (4'(k) < n) ? mem[rd_ptr + AW'(k)] : 8'h00;
   end
   always_ff @(posedge clock)
      if (wr_ok && !reset)
         for (int k = 0; k < WRITE_BYTES; k++)
            mem[wr_ptr + AW'(k)] <= data_in[8*k+:8];
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         valid_out <= 1'b0;
         data_out  <= '0;
         size_out  <= 2'b00;
      end else begin
         valid_out <= rd_ok;
         count     <= count + (wr_ok ? CW'(WRITE_BYTES) : '0) - (rd_ok ? CW'(n) : '0);
         if (wr_ok) wr_ptr <= wr_ptr + AW'(WRITE_BYTES);
         if (rd_ok) begin
            rd_ptr   <= rd_ptr + AW'(n);
            data_out <= rd_data;
            size_out <= size;
         end
      end
   end
endmodule

// File: tb/tb_fifo_var_read.sv
// tb_fifo_var_read: directed self-checking bench for fifo_var_read.
module tb_fifo_var_read;
   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        valid_in = 1'b0;
   logic [31:0] data_in = '0;
   logic        ready_in;
   logic        rd_req = 1'b0;
   logic [1:0]  size = 2'b00;
   logic        valid_out;
   logic [63:0] data_out;
   logic [1:0]  size_out;
   logic [8:0]  count;
   logic        empty;
   int checks = 0;
   int errors = 0;

   fifo_var_read dut (
      .clock(clock), .reset(reset), .valid_in(valid_in), .data_in(data_in),
      .ready_in(ready_in), .rd_req(rd_req), .size(size), .valid_out(valid_out),
      .data_out(data_out), .size_out(size_out), .count(count), .empty(empty)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1; tick(); reset = 1'b0;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_empty", 64'(empty), 64'd1);
      chk("rst_ready", 64'(ready_in), 64'd1);
      chk("rst_valid", 64'(valid_out), 64'd0);
      chk("rst_data", data_out, 64'd0);

      valid_in = 1'b1; data_in = 32'h44332211; tick();
      data_in = 32'h88776655; tick();
      valid_in = 1'b0; rd_req = 1'b1; size = 2'b11; tick();
      rd_req = 1'b0;
      chk("r8_valid", 64'(valid_out), 64'd1);
      chk("r8_data", data_out, 64'h8877665544332211);
      chk("r8_size", 64'(size_out), 64'd3);
      chk("r8_count", 64'(count), 64'd0);
      chk("r8_empty", 64'(empty), 64'd1);

      valid_in = 1'b1; data_in = 32'hDDCCBBAA; tick();
      valid_in = 1'b0; rd_req = 1'b1; size = 2'b00; tick();
      chk("mix_r1", data_out, 64'hAA);
      size = 2'b01; tick();
      chk("mix_r2", data_out, 64'hCCBB);
      chk("mix_sz2", 64'(size_out), 64'd1);
      size = 2'b00; tick();
      chk("mix_r3", data_out, 64'hDD);
      chk("mix_count", 64'(count), 64'd0);
      rd_req = 1'b0; tick();
      chk("idle_valid", 64'(valid_out), 64'd0);
      chk("idle_hold", data_out, 64'hDD);

      valid_in = 1'b1; data_in = 32'h04030201; tick();
      valid_in = 1'b0; rd_req = 1'b1; size = 2'b01; tick();
      chk("short_pre", data_out, 64'h0201);
      size = 2'b10; tick();
      chk("short_valid", 64'(valid_out), 64'd0);
      chk("short_count", 64'(count), 64'd2);
      chk("short_hold", data_out, 64'h0201);
      valid_in = 1'b1; data_in = 32'h08070605; tick();
      valid_in = 1'b0;
      chk("short_wr_valid", 64'(valid_out), 64'd0);
      chk("short_wr_count", 64'(count), 64'd6);
      tick();
      chk("short_ok_valid", 64'(valid_out), 64'd1);
      chk("short_ok_data", data_out, 64'h06050403);
      size = 2'b01; tick();
      rd_req = 1'b0;
      chk("short_tail", data_out, 64'h0807);
      chk("short_empty", 64'(count), 64'd0);

      valid_in = 1'b1;
      for (int i = 1; i <= 63; i++) begin
         data_in = 32'(i) * 32'h01010101;
         tick();
      end
      chk("fill252_count", 64'(count), 64'd252);
      chk("fill252_ready", 64'(ready_in), 64'd1);
      data_in = 32'h40404040; tick();
      chk("full_count", 64'(count), 64'd256);
      chk("full_ready", 64'(ready_in), 64'd0);
      data_in = 32'hDEADBEEF; tick();
      chk("full_block", 64'(count), 64'd256);
      rd_req = 1'b1; size = 2'b10; tick();
      valid_in = 1'b0; rd_req = 1'b0;
      chk("full_rw_count", 64'(count), 64'd252);
      chk("full_rw_data", data_out, 64'h01010101);
      chk("full_rw_ready", 64'(ready_in), 64'd1);

      reset = 1'b1; tick(); reset = 1'b0;
      size = 2'b10;
      for (int i = 0; i < 63; i++) begin
         valid_in = 1'b1; data_in = 32'h11111111 * 32'(i % 15); tick();
         valid_in = 1'b0; rd_req = 1'b1; tick();
         rd_req = 1'b0;
      end
      chk("adv_count", 64'(count), 64'd0);
      valid_in = 1'b1; data_in = 32'h03020100; tick();
      data_in = 32'h07060504; tick();
      valid_in = 1'b0; rd_req = 1'b1; size = 2'b11; tick();
      rd_req = 1'b0;
      chk("wrap_data", data_out, 64'h0706050403020100);
      chk("wrap_valid", 64'(valid_out), 64'd1);
      chk("wrap_count", 64'(count), 64'd0);

      valid_in = 1'b1;
      for (int i = 0; i < 10; i++) begin
         data_in = 32'hA0A0A0A0 + 32'(i); tick();
      end
      chk("pre_rst_count", 64'(count), 64'd40);
      reset = 1'b1; rd_req = 1'b1; size = 2'b10; tick();
      reset = 1'b0; valid_in = 1'b0;
      chk("mid_rst_count", 64'(count), 64'd0);
      chk("mid_rst_valid", 64'(valid_out), 64'd0);
      chk("mid_rst_data", data_out, 64'd0);
      chk("mid_rst_size", 64'(size_out), 64'd0);
      size = 2'b00; tick();
      chk("post_rst_rej", 64'(valid_out), 64'd0);
      chk("post_rst_cnt", 64'(count), 64'd0);
      valid_in = 1'b1; data_in = 32'h0000005A; tick();
      valid_in = 1'b0;
      chk("post_wr_rej", 64'(valid_out), 64'd0);
      chk("post_wr_cnt", 64'(count), 64'd4);
      tick();
      rd_req = 1'b0;
      chk("post_rd_valid", 64'(valid_out), 64'd1);
      chk("post_rd_data", data_out, 64'h5A);
      chk("post_rd_cnt", 64'(count), 64'd3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
